// File: rtl/ula_pkg.sv
// Shared opcode constants and FSM state encoding for the ULA arbiter.
package ula_pkg;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_ADDU = 4'b0100;
   localparam logic [3:0] OP_SUBU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_MULU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_BRK  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;
endpackage

// File: rtl/ula_arb_pick.sv
// Combinational one-hot grant for two requesters; ptr_i selects the tie winner.
module ula_arb_pick (
   input  logic [1:0] req_valid_i,
   input  logic       ptr_i,
   input  logic       halt_i,
   output logic [1:0] grant_o
);
   always_comb begin
      grant_o = 2'b00;
      if (!halt_i) begin
         if (req_valid_i == 2'b11) grant_o = ptr_i ? 2'b10 : 2'b01;
         else                      grant_o = req_valid_i;
      end
   end
endmodule

// File: rtl/ula_arbiter.sv
// Two-requester front end for a single shared ULA: IDLE -> ISSUE -> RESP.
// Define ULA_ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority.
module ula_arbiter
   import ula_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_z,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_z,
   output logic             halt
);
   state_e           state_q, state_d;
   logic             grant_id_q, brk_q, halt_q, rsp_z_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_s_q;
   logic [OPW-1:0]   alu_op_q;
   logic [1:0]       grant;
   logic             ptr, accept, gsel, sel_brk;
   logic [OPW-1:0]   sel_op;

   assign accept  = (state_q == ST_IDLE) && (grant != 2'b00);
   assign gsel    = grant[1];
   assign sel_op  = gsel ? req1_op : req0_op;
   assign sel_brk = (sel_op == OPW'(OP_BRK));

`ifdef ULA_ARB_ROUND_ROBIN_EN
   logic ptr_q;
   always_ff @(posedge clk) begin
      if (reset)       ptr_q <= 1'b0;
      else if (accept) ptr_q <= ~ptr_q;
   end
   assign ptr = ptr_q;
`else
   assign ptr = 1'b0;
`endif

   ula_arb_pick u_pick (
      .req_valid_i (req_valid),
      .ptr_i       (ptr),
      .halt_i      (halt_q),
      .grant_o     (grant)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      case (state_q)
         ST_IDLE: begin
            req_ready = grant;
            if (accept) state_d = ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid[grant_id_q] = 1'b1;
            if (rsp_ready[grant_id_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         grant_id_q <= 1'b0;
         brk_q      <= 1'b0;
         halt_q     <= 1'b0;
         rsp_s_q    <= '0;
         rsp_z_q    <= 1'b0;
      end else begin
         if (accept) begin
            alu_a_q    <= gsel ? req1_a : req0_a;
            alu_b_q    <= gsel ? req1_b : req0_b;
            // Break never reaches the ULA; it completes with a zero result.
            alu_op_q   <= sel_brk ? '0 : sel_op;
            grant_id_q <= gsel;
            brk_q      <= sel_brk;
            if (sel_brk) halt_q <= 1'b1;
         end
         if (state_q == ST_ISSUE) begin
            rsp_s_q <= brk_q ? '0 : alu_s;
            rsp_z_q <= brk_q | alu_z;
         end
      end
   end

   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = alu_op_q;
   assign rsp_s  = rsp_s_q;
   assign rsp_z  = rsp_z_q;
   assign halt   = halt_q;
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed + randomized bench for ula_arbiter with a transaction-level reference model.
module tb_ula_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] rsp_s, alu_a, alu_b, alu_s;
   logic        rsp_z, alu_z, halt;
   logic [3:0]  alu_op;

   int vectors = 0;
   int errors  = 0;
   int ptr_m   = 0;
   bit halt_m  = 1'b0;

   always #5 clk = ~clk;

   // Reference ULA behaviour, straight from the opcode table.
   function automatic logic [31:0] ula_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010, 4'b0100: return a + b;
         4'b0011: return a ^ b;
         4'b0101, 4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000, 4'b1001: return a * b;
         4'b1100: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_s = ula_f(alu_op, alu_a, alu_b);
   assign alu_z = (alu_s == 32'd0);

   ula_arbiter #(.WIDTH(32), .OPW(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_s(rsp_s), .rsp_z(rsp_z),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_s(alu_s), .alu_z(alu_z), .halt(halt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_s", rsp_s, 32'd0);
      chk("rst_rsp_z", rsp_z, 1'b0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", alu_op, 4'd0);
      chk("rst_halt", halt, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; ptr_m = 0; halt_m = 1'b0;
      #1 check_reset();
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      if (r == 0) begin req0_a = a; req0_b = b; req0_op = op; end
      else        begin req1_a = a; req1_b = b; req1_op = op; end
      req_valid[r] = 1'b1;
   endtask

   // One full transaction from whatever req_valid currently shows; returns at a negedge in IDLE.
   task automatic serve(input int rdly, input bit noise);
      int w;
      logic [1:0] er;
      logic [31:0] ea, eb, es;
      logic [3:0] eo;
      logic ez, brk;
      #1;
      if (halt_m || req_valid == 2'b00) w = -1;
      else if (req_valid == 2'b11)      w = ptr_m;
      else                              w = req_valid[1] ? 1 : 0;
      er = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      chk("accept_ready", req_ready, er);
      if (w < 0) begin
         @(negedge clk);
         return;
      end
      ea  = (w == 0) ? req0_a  : req1_a;
      eb  = (w == 0) ? req0_b  : req1_b;
      eo  = (w == 0) ? req0_op : req1_op;
      brk = (eo == 4'b1111);
      es  = brk ? 32'd0 : ula_f(eo, ea, eb);
      ez  = brk ? 1'b1 : (es == 32'd0);
      @(posedge clk);
`ifdef ULA_ARB_ROUND_ROBIN_EN
      ptr_m = 1 - ptr_m;
`endif
      if (brk) halt_m = 1'b1;
      @(negedge clk);
      req_valid[w] = 1'b0;
      #1;
      chk("issue_alu_a", alu_a, ea);
      chk("issue_alu_b", alu_b, eb);
      chk("issue_alu_op", alu_op, brk ? 4'b0000 : eo);
      chk("issue_req_ready", req_ready, 2'b00);
      chk("issue_rsp_valid", rsp_valid, 2'b00);
      chk("issue_halt", halt, halt_m);
      @(negedge clk);
      for (int k = 0; k < rdly; k++) begin
         rsp_ready = noise ? ~er : 2'b00;
         #1;
         chk("hold_rsp_valid", rsp_valid, er);
         chk("hold_rsp_s", rsp_s, es);
         chk("hold_rsp_z", rsp_z, ez);
         chk("hold_req_ready", req_ready, 2'b00);
         @(negedge clk);
      end
      rsp_ready = er;
      #1;
      chk("resp_valid", rsp_valid, er);
      chk("resp_s", rsp_s, es);
      chk("resp_z", rsp_z, ez);
      @(negedge clk);
      rsp_ready = 2'b00;
      #1 chk("resp_done", rsp_valid, 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 check_reset();
      do_reset();

      // Single ADD from requester 0.
      set_req(0, 32'd5, 32'd7, 4'b0010);
      serve(0, 1'b0);

      // Tie: SUB 9,9 vs OR 1,2, then a second tie.
      do_reset();
      set_req(0, 32'd9, 32'd9, 4'b0110);
      set_req(1, 32'd1, 32'd2, 4'b0001);
      serve(0, 1'b1);
      serve(0, 1'b0);
      set_req(0, 32'd1, 32'd1, 4'b0010);
      set_req(1, 32'd3, 32'd3, 4'b0011);
      serve(1, 1'b1);
      serve(0, 1'b0);

      // Response held back for 5 cycles.
      set_req(1, 32'hFFFF_FFFF, 32'd2, 4'b0111);
      serve(5, 1'b0);

      // Four consecutive ties.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_req(0, 32'd100 + 32'(i), 32'd3, 4'b1000);
         set_req(1, 32'd7, 32'(i), 4'b1100);
         serve(0, 1'b0);
      end
      serve(0, 1'b0);

      // Randomized traffic, no break ops.
      for (int i = 0; i < 150; i++) begin
         if (req_valid == 2'b00) begin
            logic [1:0] pat;
            pat = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
               if (pat[r]) begin
                  logic [31:0] a, b;
                  a = $urandom;
                  b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                  set_req(r, a, b, 4'($urandom_range(0, 14)));
               end
            end
         end
         serve($urandom_range(0, 3), 1'($urandom));
      end
      while (req_valid != 2'b00) serve(0, 1'b0);

      // Reset while in ISSUE drops the op.
      set_req(0, 32'd4, 32'd4, 4'b0010);
      #1 chk("rstmid_accept", req_ready, 2'b01);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; ptr_m = 0; halt_m = 1'b0;
      #1 check_reset();
      @(negedge clk);
      #1 chk("rstmid_no_rsp", rsp_valid, 2'b00);

      // Break op from requester 1, then nothing is accepted.
      set_req(1, 32'd123, 32'd456, 4'b1111);
      serve(1, 1'b0);
      set_req(0, 32'd1, 32'd2, 4'b0010);
      set_req(1, 32'd3, 32'd4, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("halt_req_ready", req_ready, 2'b00);
         chk("halt_rsp_valid", rsp_valid, 2'b00);
         chk("halt_sticky", halt, 1'b1);
         chk("halt_alu_op", alu_op, 4'b0000);
         @(negedge clk);
      end
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
